dac_buf: RTL and testbench
==========================

Name: dac_buf

Overview:
- Asymmetric simple dual-port sample buffer for the audio DAC path.
- Port A: byte-wide write port, filled by the MCU/programming interface.
- Port B: 32-bit-wide synchronous read port, fetched by the DAC engine. Each word holds one stereo 16-bit sample pair.
- Total capacity 2048 bytes = 512 words; both ports share a single clock.

Parameters:
- ADDRA_W, 11, byte write-address width (depth 2^ADDRA_W bytes).
- ADDRB_W, 9, word read-address width; must equal ADDRA_W-2.
- Width ratio is fixed at 4 bytes per word. DATA_A = 8 and DATA_B = 32 are not parameters.

Ports:
- clkin  in  1  single clock for both ports; all sampling on rising edge.
- reset  in  1  asynchronous, active-high; clears the read output register only.
- wea  in  1  write enable, active-high (the parent drives it as the inverted active-low bus strobe).
- addra  in  11  byte write address.
- dina  in  8  write data byte.
- addrb  in  9  word read address.
- doutb  out  32  registered read data.

Behaviour:
- Storage
  - 2048 x 8-bit array, logically also addressed as 512 x 32-bit.
  - All locations are 0 at configuration/power-up (initialised array).
  - reset does not alter array contents.
- Write (port A)
  - On the rising clkin edge with wea=1, the array byte at addra takes dina.
  - wea=0: no change.
  - No write-side latency constraint; the written byte is visible to a port-B read issued in the next cycle.
- Word mapping (little-endian)
  - Word W = bytes {4W+3, 4W+2, 4W+1, 4W}.
  - doutb[7:0] = byte 4W, doutb[15:8] = 4W+1, doutb[23:16] = 4W+2, doutb[31:24] = 4W+3.
  - So doutb[15:0] is the first 16-bit LE sample (channel 0) and doutb[31:16] is the second (channel 1).
  - Byte address A maps to word A[10:2], lane A[1:0].
- Read (port B)
  - Synchronous, 1-cycle latency: doutb after edge N reflects the word at the addrb sampled at edge N.
  - doutb is held constant while addrb is unchanged and no write hits that word.
  - Read enable is implicit (always reading).
- Read/write collision
  - Same cycle, write byte lies inside the word being read: read-first.
  - doutb returns the old byte for that lane; the new value appears on the following read.
  - Other lanes are unaffected.
- Reset
  - reset=1 asynchronously forces doutb = 32'h0 and holds it while asserted.
  - Writes on port A are still accepted during reset.
  - The first clkin edge after reset deassertion loads doutb from the current addrb.
- Address wrap
  - Full-width addresses, no out-of-range cases.
  - addra 0x7FF writes word 0x1FF lane 3.
  - addrb increments wrap 0x1FF -> 0x000 naturally in the parent.
- Implementation
  - Must infer block RAM: byte-lane write enables decoded from addra[1:0], one registered 32-bit read.
  - No combinational path from inputs to doutb.

Test Plan:
- Power-up, no writes: read addrb 0x000 and 0x1FF -> doutb = 0x00000000 one cycle after each address.
- Write bytes 0x11, 0x22, 0x33, 0x44 at addra 0x000–0x003, then addrb = 0 -> next cycle doutb = 0x44332211.
- Write 0xAA at addra 0x7FF, read addrb 0x1FF -> doutb[31:24] = 0xAA, other lanes 0. Also read addrb 0x000 -> still 0x44332211 (no aliasing).
- Collision: addrb = 1 held; same edge write 0x5A at addra 0x005 -> doutb after that edge = old word; after next edge lane 1 = 0x5A.
- Pulse reset mid-stream with addrb = 0 -> doutb goes 0 immediately, without waiting for a clock edge. After release, next edge doutb = 0x44332211 (contents retained).
- wea = 0 with changing addra/dina for 16 cycles -> all previously read words unchanged.

Source files
------------

// File: rtl/dac_buf.sv
// dac_buf -- asymmetric simple dual-port sample buffer for the audio DAC path.
//
// A byte-wide write port (A) is filled by the MCU side. A 32-bit registered
// read port (B) is fetched by the DAC engine. Each 32-bit word holds one stereo
// pair of 16-bit little-endian samples: doutb[15:0] is channel 0 and
// doutb[31:16] is channel 1. Both ports run on a single clock.
//
// Ports:
//   clkin  - shared clock; everything samples on the rising edge
//   reset  - async active-high; clears only the read output register
//   wea    - byte write enable (active-high)
//   addra  - byte write address; word = addra[MSB:2], lane = addra[1:0]
//   dina   - write data byte
//   addrb  - word read address
//   doutb  - registered read word, one cycle after addrb is sampled
module dac_buf #(
    parameter int unsigned ADDRA_W = 11,
    parameter int unsigned ADDRB_W = 9
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               wea,
    input  logic [ADDRA_W-1:0] addra,
    input  logic [7:0]         dina,
    input  logic [ADDRB_W-1:0] addrb,
    output logic [31:0]        doutb
);

    localparam int unsigned WORDS = 1 << ADDRB_W;

    // Word-organised storage with four byte lanes so that synthesis sees a
    // single block RAM with per-lane write enables. Contents start at zero
    // from the configuration image and are never touched by reset.
    logic [3:0][7:0] mem [WORDS] = '{default: '0};

    logic [ADDRB_W-1:0] wr_word;
    logic [3:0]         lane_we;
    logic [31:0]        doutb_d;
    logic [31:0]        doutb_q;

    // Byte address splits into a word index and a lane select.
    always_comb begin
        wr_word = addra[ADDRA_W-1:2];
        lane_we = '0;
        if (wea) begin
            lane_we[addra[1:0]] = 1'b1;
        end
    end

    // Write port: only the addressed lane of the addressed word changes.
    always_ff @(posedge clkin) begin
        for (int unsigned l = 0; l < 4; l++) begin
            if (lane_we[l]) begin
                mem[wr_word][l] <= dina;
            end
        end
    end

    // Read data is taken from the array before this edge's write lands, so a
    // same-cycle write into the word being read returns the old byte
    // (read-first); the new byte shows up on the following read.
    always_comb begin
        doutb_d = mem[addrb];
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            doutb_q <= '0;
        end else begin
            doutb_q <= doutb_d;
        end
    end

    assign doutb = doutb_q;

endmodule

// File: tb/tb_dac_buf.sv
module tb_dac_buf;

    logic        clkin = 1'b0;
    logic        reset;
    logic        wea;
    logic [10:0] addra;
    logic [7:0]  dina;
    logic [8:0]  addrb;
    logic [31:0] doutb;

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          checking = 1'b0;

    // Reference model: a flat byte array plus the expected output word.
    logic [7:0]  bytes_m [2048];
    logic [31:0] exp_out = '0;

    dac_buf #(.ADDRA_W(11), .ADDRB_W(9)) dut (
        .clkin (clkin),
        .reset (reset),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb)
    );

    always #5 clkin = ~clkin;

    function automatic logic [31:0] model_word(input logic [8:0] w);
        int unsigned base;
        base = 4 * int'(w);
        return {bytes_m[base + 3], bytes_m[base + 2], bytes_m[base + 1], bytes_m[base]};
    endfunction

    // Model: read the word before applying the byte write (read-first).
    always @(posedge clkin) begin
        if (reset) exp_out = '0;
        else       exp_out = model_word(addrb);
        if (wea === 1'b1) bytes_m[addra] = dina;
    end

    always @(posedge reset) exp_out = '0;

    // Per-cycle comparison against the model.
    always @(negedge clkin) begin
        if (checking) begin
            total++;
            if (doutb !== exp_out) begin
                bad++;
                $display("FAIL model_cmp t=%0t addrb=%h got=%h exp=%h", $time, addrb, doutb, exp_out);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] expv);
        total++;
        if (doutb !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, doutb, expv);
        end
    endtask

    task automatic cyc();
        @(negedge clkin);
    endtask

    task automatic wr(input logic [10:0] a, input logic [7:0] d);
        wea = 1'b1; addra = a; dina = d;
        cyc();
        wea = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) bytes_m[i] = '0;
        reset = 1'b0; wea = 1'b0; addra = '0; dina = '0; addrb = '0;
        #1 reset = 1'b1;
        cyc();
        checking = 1'b1;
        cyc();
        lit("reset_state", 32'h0);
        reset = 1'b0;

        // Power-up contents are zero.
        addrb = 9'h000; cyc();
        lit("pwrup_w000", 32'h0);
        addrb = 9'h1FF; cyc();
        lit("pwrup_w1ff", 32'h0);

        // Little-endian packing of four bytes into word 0.
        wr(11'h000, 8'h11);
        wr(11'h001, 8'h22);
        wr(11'h002, 8'h33);
        wr(11'h003, 8'h44);
        addrb = 9'h000; cyc();
        lit("le_word0", 32'h44332211);

        // Top byte address lands in word 0x1FF lane 3, no aliasing onto word 0.
        wr(11'h7FF, 8'hAA);
        addrb = 9'h1FF; cyc();
        lit("top_lane3", 32'hAA000000);
        addrb = 9'h000; cyc();
        lit("no_alias", 32'h44332211);

        // Collision: read word 1 while writing its lane 1 on the same edge.
        addrb = 9'h001; cyc();
        lit("coll_pre", 32'h0);
        wr(11'h005, 8'h5A);
        lit("coll_old", 32'h0);
        cyc();
        lit("coll_new", 32'h00005A00);

        // Asynchronous reset mid-stream; writes still accepted during reset.
        addrb = 9'h000; cyc();
        lit("pre_reset", 32'h44332211);
        #2 reset = 1'b1;
        #1 lit("async_clear", 32'h0);
        cyc();
        wr(11'h008, 8'h77);
        lit("reset_hold", 32'h0);
        reset = 1'b0;
        cyc();
        lit("post_reset", 32'h44332211);
        addrb = 9'h002; cyc();
        lit("wr_in_reset", 32'h00000077);

        // wea low with busy address/data lines must not disturb anything.
        for (int i = 0; i < 16; i++) begin
            addra = 11'(i * 37 + 3);
            dina  = 8'(i * 13 + 1);
            cyc();
        end
        addrb = 9'h000; cyc();
        lit("idle_w000", 32'h44332211);
        addrb = 9'h001; cyc();
        lit("idle_w001", 32'h00005A00);
        addrb = 9'h1FF; cyc();
        lit("idle_w1ff", 32'hAA000000);
        addrb = 9'h002; cyc();
        lit("idle_w002", 32'h00000077);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
